// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared widths, starvation limit and FSM state type for the data memory arbiter
package data_mem_arb_pkg;
    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 4;
    localparam int STARVE_LIM = 4;
    localparam int STARVE_W   = $clog2(STARVE_LIM + 1);
    typedef enum logic {IDLE, BURST} state_e;
endpackage

// File: rtl/burst_addr_gen.sv
// burst_addr_gen: latched burst address with modulo-64 increment and remaining-beat counter
// Ports: clk_i, rst_ni (async active-low), load_i (first beat: take addr_i+1 / len_i),
//        step_i (burst beat: advance address, count down), addr_o (next beat address),
//        last_o (the next beat is the final one)
module burst_addr_gen
    import data_mem_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    // Address arithmetic is ADDR_W wide, so 63 naturally wraps to 0.
    always_comb begin
        addr_d = load_i ? addr_i + ADDR_W'(1) : step_i ? addr_q + ADDR_W'(1) : addr_q;
        rem_d  = load_i ? len_i : step_i ? rem_q - LEN_W'(1) : rem_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = rem_q == LEN_W'(1);
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter/sequencer in front of the 64x32 data memory
// Ports: port 0 (m0_*) single-beat pipeline accesses, default priority;
//        port 1 (m1_*) single beats or auto-incrementing bursts, forced a grant after STARVE_LIM denials;
//        mem_* drive the memory, mem_rd_i is its combinational read data;
//        m*_rvalid_o/m*_rdata_o return read data one cycle after the grant.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [LEN_W-1:0]  m1_len_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_busy_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    output logic              mem_memwrite_o,
    output logic              mem_memread_o,
    input  logic [DATA_W-1:0] mem_rd_i
);
    state_e              state_q;
    logic                we_q, busy_q;
    logic [STARVE_W-1:0] starve_q;
    logic                rv0_q, rv1_q, rv0_d, rv1_d;
    logic [DATA_W-1:0]   rd0_q, rd1_q;
    logic                p1_req, p1_we, gnt0, gnt1, last;
    logic [ADDR_W-1:0]   p1_addr, burst_addr;

    burst_addr_gen u_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (gnt1 && state_q == IDLE),
        .step_i (gnt1 && state_q == BURST),
        .addr_i (m1_addr_i),
        .len_i  (m1_len_i),
        .addr_o (burst_addr),
        .last_o (last)
    );

    // Inside a burst port 1 requests every cycle from its latched context.
    // Grants are masked by rst_ni so nothing reaches memory while reset is held.
    always_comb begin
        p1_req  = state_q == BURST || m1_req_i;
        p1_we   = state_q == BURST ? we_q : m1_we_i;
        p1_addr = state_q == BURST ? burst_addr : m1_addr_i;
        gnt1    = rst_ni && p1_req && (!m0_req_i || starve_q == STARVE_W'(STARVE_LIM));
        gnt0    = rst_ni && m0_req_i && !gnt1;
        rv0_d   = gnt0 && !m0_we_i;
        rv1_d   = gnt1 && !p1_we;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            starve_q <= (gnt1 || !p1_req) ? '0 :
                        starve_q == STARVE_W'(STARVE_LIM) ? starve_q : starve_q + STARVE_W'(1);
            if (state_q == IDLE && gnt1) begin
                we_q <= m1_we_i;
                if (m1_len_i != '0) begin
                    state_q <= BURST;
                    busy_q  <= 1'b1;
                end
            end else if (state_q == BURST && gnt1 && last) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end

    // rdata only loads on a read grant, so stale memory X never leaks out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            rv0_q <= rv0_d;
            rv1_q <= rv1_d;
            rd0_q <= rv0_d ? mem_rd_i : rd0_q;
            rd1_q <= rv1_d ? mem_rd_i : rd1_q;
        end
    end

    assign m0_gnt_o       = gnt0;
    assign m1_gnt_o       = gnt1;
    assign m0_rvalid_o    = rv0_q;
    assign m1_rvalid_o    = rv1_q;
    assign m0_rdata_o     = rd0_q;
    assign m1_rdata_o     = rd1_q;
    assign m1_busy_o      = busy_q;
    assign mem_addr_o     = gnt0 ? m0_addr_i : gnt1 ? p1_addr : '0;
    assign mem_wd_o       = gnt0 ? m0_wdata_i : gnt1 ? m1_wdata_i : '0;
    assign mem_memwrite_o = (gnt0 && m0_we_i) || (gnt1 && p1_we);
    assign mem_memread_o  = (gnt0 && !m0_we_i) || (gnt1 && !p1_we);
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed self-checking bench for data_mem_arbiter with a behavioural 64x32 memory
module tb_data_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [5:0]  m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [5:0]  m1_addr = '0;
    logic [3:0]  m1_len = '0;
    logic [31:0] m1_wdata = '0;
    logic        m1_gnt, m1_rvalid, m1_busy;
    logic [31:0] m1_rdata;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wd, mem_rd;
    logic        mem_memwrite, mem_memread;
    logic [31:0] mem_q [64];
    bit   [63:0] vld_q;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_len_i(m1_len),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o(m1_rdata), .m1_busy_o(m1_busy),
        .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_memwrite_o(mem_memwrite),
        .mem_memread_o(mem_memread), .mem_rd_i(mem_rd)
    );

    // Unwritten words read as 0xA00000xx (xx = address) so every word is distinct.
    always @(posedge clk) begin
        if (mem_memwrite) begin
            mem_q[mem_addr] <= mem_wd;
            vld_q[mem_addr] <= 1'b1;
        end
    end
    always_comb mem_rd = vld_q[mem_addr] ? mem_q[mem_addr] : (32'hA000_0000 | 32'(mem_addr));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd0(input logic [5:0] a, input logic [31:0] exp, input string tag);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = a;
        #1 check({tag, "_gnt"}, 32'(m0_gnt), 1);
        cyc();
        m0_req = 1'b0;
        #1 check({tag, "_rv"}, 32'(m0_rvalid), 1);
        check({tag, "_rd"}, m0_rdata, exp);
    endtask

    initial begin
        // reset state, with a port-0 request asserted to prove grants are masked
        m0_req = 1'b1; m0_we = 1'b1;
        #2;
        check("rst_m0_gnt", 32'(m0_gnt), 0);
        check("rst_memwrite", 32'(mem_memwrite), 0);
        check("rst_rv0", 32'(m0_rvalid), 0);
        check("rst_rv1", 32'(m1_rvalid), 0);
        check("rst_rd0", m0_rdata, 0);
        check("rst_rd1", m1_rdata, 0);
        check("rst_busy", 32'(m1_busy), 0);
        m0_req = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // port 0 write then read-after-write
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd5; m0_wdata = 32'hDEAD_BEEF;
        #1 check("w0_gnt", 32'(m0_gnt), 1);
        check("w0_memwrite", 32'(mem_memwrite), 1);
        check("w0_addr", 32'(mem_addr), 5);
        check("w0_wd", mem_wd, 32'hDEAD_BEEF);
        cyc();
        m0_we = 1'b0;
        #1 check("r0_gnt", 32'(m0_gnt), 1);
        check("r0_memread", 32'(mem_memread), 1);
        check("r0_rv_early", 32'(m0_rvalid), 0);
        cyc();
        m0_req = 1'b0;
        #1 check("r0_rv", 32'(m0_rvalid), 1);
        check("r0_rd", m0_rdata, 32'hDEAD_BEEF);
        check("idle_addr", 32'(mem_addr), 0);
        cyc();
        check("r0_rv_drop", 32'(m0_rvalid), 0);
        check("r0_rd_hold", m0_rdata, 32'hDEAD_BEEF);

        // port 1 read burst 60..3 wrapping
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd60; m1_len = 4'd7;
        #1 check("b_gnt0", 32'(m1_gnt), 1);
        check("b_addr0", 32'(mem_addr), 60);
        cyc();
        m1_req = 1'b0; m1_addr = 6'd9; m1_len = 4'd0;
        for (int k = 1; k < 8; k++) begin
            #1 check("b_gnt", 32'(m1_gnt), 1);
            check("b_addr", 32'(mem_addr), 32'((60 + k) % 64));
            check("b_busy", 32'(m1_busy), 1);
            check("b_rv", 32'(m1_rvalid), 1);
            check("b_rd", m1_rdata, 32'hA000_0000 | 32'((60 + k - 1) % 64));
            cyc();
        end
        #1 check("b_rv_last", 32'(m1_rvalid), 1);
        check("b_rd_last", m1_rdata, 32'hA000_0003);
        check("b_busy_end", 32'(m1_busy), 0);
        check("b_gnt_end", 32'(m1_gnt), 0);
        cyc();

        // starvation: port 1 wins every 5th cycle
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd2; m1_len = 4'd0;
        for (int i = 0; i < 10; i++) begin
            #1 check("st_m1", 32'(m1_gnt), 32'(i % 5 == 4));
            check("st_m0", 32'(m0_gnt), 32'(i % 5 != 4));
            cyc();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        cyc();

        // plain priority, then port 1 once port 0 drops
        m0_req = 1'b1; m1_req = 1'b1;
        #1 check("pr_m0", 32'(m0_gnt), 1);
        check("pr_m1", 32'(m1_gnt), 0);
        cyc();
        m0_req = 1'b0;
        #1 check("pr_m1_next", 32'(m1_gnt), 1);
        cyc();
        m1_req = 1'b0;
        #1 check("pr_rv1", 32'(m1_rvalid), 1);
        check("pr_rd1", m1_rdata, 32'hA000_0002);
        cyc();

        // 16-beat write burst at 20, reset during beat 3
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd20; m1_len = 4'd15; m1_wdata = 32'h5000_0000;
        cyc();
        m1_req = 1'b0; m1_wdata = 32'h5000_0001;
        #1 check("rb_busy", 32'(m1_busy), 1);
        check("rb_addr1", 32'(mem_addr), 21);
        cyc();
        m1_wdata = 32'h5000_0002;
        #1 check("rb_gnt3", 32'(m1_gnt), 1);
        rst_n = 1'b0;
        #1 check("rb_busy_rst", 32'(m1_busy), 0);
        check("rb_gnt_rst", 32'(m1_gnt), 0);
        check("rb_wr_rst", 32'(mem_memwrite), 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("rb_post_wr", 32'(mem_memwrite), 0);
            check("rb_post_busy", 32'(m1_busy), 0);
            cyc();
        end
        rd0(6'd20, 32'h5000_0000, "rb20");
        rd0(6'd21, 32'h5000_0001, "rb21");
        rd0(6'd22, 32'hA000_0016, "rb22");
        rd0(6'd35, 32'hA000_0023, "rb35");

        // single-beat write via port 1
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd10; m1_len = 4'd0; m1_wdata = 32'h1234_5678;
        #1 check("s_gnt", 32'(m1_gnt), 1);
        check("s_memwrite", 32'(mem_memwrite), 1);
        check("s_addr", 32'(mem_addr), 10);
        cyc();
        m1_req = 1'b0;
        #1 check("s_busy", 32'(m1_busy), 0);
        check("s_no_wr", 32'(mem_memwrite), 0);
        rd0(6'd10, 32'h1234_5678, "s10");
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
